// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and helpers for the 4x4 matrix keypad scanner.
//   ROWS, COLS    : matrix geometry
//   key_state_t   : debounce FSM states
//   scan_res_t    : classification of one full four-row scan
//   col_index()   : column bit -> 2-bit column number (lowest set bit wins)
//   bit_count_sat(): number of set column bits, saturating at 2
package keypad_pkg;

    localparam int ROWS = 4;
    localparam int COLS = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        RELEASE  = 2'd3
    } key_state_t;

    typedef enum logic [1:0] {
        NONE   = 2'd0,
        SINGLE = 2'd1,
        MULTI  = 2'd2
    } scan_res_t;

    // Lowest set bit decides, so a multi-bit sample still yields a defined index.
    function automatic logic [1:0] col_index(input logic [3:0] c);
        logic [1:0] idx;
        if (c[0]) begin
            idx = 2'd0;
        end else if (c[1]) begin
            idx = 2'd1;
        end else if (c[2]) begin
            idx = 2'd2;
        end else if (c[3]) begin
            idx = 2'd3;
        end else begin
            idx = 2'd0;
        end
        return idx;
    endfunction

    // 0, 1 or "2 or more" set bits; exact counts above one are irrelevant.
    function automatic logic [1:0] bit_count_sat(input logic [3:0] c);
        logic [2:0] sum;
        sum = {2'b00, c[0]} + {2'b00, c[1]} + {2'b00, c[2]} + {2'b00, c[3]};
        return (sum >= 3'd2) ? 2'd2 : sum[1:0];
    endfunction

endpackage

// File: rtl/keypad_debounce.sv
// keypad_debounce: per-scan debounce / N-key-lockout FSM.
// Ports:
//   clk190hz  in   scan clock
//   rst_n     in   async active-low reset
//   res_valid in   high on the edge that completes a full scan
//   res       in   NONE / SINGLE / MULTI for that scan
//   res_code  in   key code when res == SINGLE
//   key_code  out  last accepted code
//   key_valid out  one-cycle accept (or repeat) pulse
//   key_held  out  high from acceptance until debounced release
// Optional: KEYPAD_REPEAT_EN adds the auto-repeat counter.
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_SCANS = 2
`ifdef KEYPAD_REPEAT_EN
    ,
    parameter int REPEAT_SCANS = 24
`endif
) (
    input  logic       clk190hz,
    input  logic       rst_n,
    input  logic       res_valid,
    input  scan_res_t  res,
    input  logic [3:0] res_code,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam logic [3:0] DB_TARGET = 4'(DEBOUNCE_SCANS);

    key_state_t state_r, state_s;
    logic [3:0] cnt_r, cnt_s, cnt_inc_s;
    logic [3:0] cand_r, cand_s;
    logic [3:0] code_r, code_s;
    logic       valid_r, valid_s;
    logic       held_r, held_s;
`ifdef KEYPAD_REPEAT_EN
    localparam logic [7:0] REP_TARGET = 8'(REPEAT_SCANS);
    logic [7:0] rep_r, rep_s, rep_inc_s;
`endif

    // Saturating increments: a stuck count can never wrap back to a match.
    always_comb begin
        cnt_inc_s = (cnt_r == 4'hF) ? cnt_r : cnt_r + 4'd1;
`ifdef KEYPAD_REPEAT_EN
        rep_inc_s = (rep_r == 8'hFF) ? rep_r : rep_r + 8'd1;
`endif
    end

    // Next-state and output logic, evaluated only when a scan completes.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        cand_s  = cand_r;
        code_s  = code_r;
        valid_s = 1'b0;
        held_s  = held_r;
`ifdef KEYPAD_REPEAT_EN
        rep_s   = rep_r;
`endif
        if (res_valid) begin
            case (state_r)
                IDLE: begin
                    if (res == SINGLE) begin
                        cand_s = res_code;
                        cnt_s  = 4'd1;
                        if (DB_TARGET == 4'd1) begin
                            code_s  = res_code;
                            valid_s = 1'b1;
                            held_s  = 1'b1;
                            state_s = PRESSED;
`ifdef KEYPAD_REPEAT_EN
                            rep_s   = 8'd0;
`endif
                        end else begin
                            state_s = DEBOUNCE;
                        end
                    end else begin
                        state_s = IDLE;
                    end
                end
                DEBOUNCE: begin
                    if ((res == SINGLE) && (res_code == cand_r)) begin
                        cnt_s = cnt_inc_s;
                        if (cnt_inc_s >= DB_TARGET) begin
                            code_s  = cand_r;
                            valid_s = 1'b1;
                            held_s  = 1'b1;
                            state_s = PRESSED;
`ifdef KEYPAD_REPEAT_EN
                            rep_s   = 8'd0;
`endif
                        end else begin
                            state_s = DEBOUNCE;
                        end
                    end else begin
                        cnt_s   = 4'd0;
                        state_s = IDLE;
                    end
                end
                PRESSED: begin
                    if (res == NONE) begin
`ifdef KEYPAD_REPEAT_EN
                        rep_s = 8'd0;
`endif
                        if (DB_TARGET == 4'd1) begin
                            cnt_s   = 4'd0;
                            held_s  = 1'b0;
                            state_s = IDLE;
                        end else begin
                            cnt_s   = 4'd1;
                            state_s = RELEASE;
                        end
                    end else begin
                        // Other keys are locked out; only the accepted code can repeat.
                        state_s = PRESSED;
`ifdef KEYPAD_REPEAT_EN
                        if ((res == SINGLE) && (res_code == code_r)) begin
                            if (rep_inc_s >= REP_TARGET) begin
                                valid_s = 1'b1;
                                rep_s   = 8'd0;
                            end else begin
                                rep_s   = rep_inc_s;
                            end
                        end else begin
                            rep_s = rep_r;
                        end
`endif
                    end
                end
                RELEASE: begin
                    if (res == NONE) begin
                        cnt_s = cnt_inc_s;
                        if (cnt_inc_s >= DB_TARGET) begin
                            cnt_s   = 4'd0;
                            held_s  = 1'b0;
                            state_s = IDLE;
                        end else begin
                            state_s = RELEASE;
                        end
                    end else begin
                        cnt_s   = 4'd0;
                        state_s = PRESSED;
                    end
                end
                default: begin
                    cnt_s   = 4'd0;
                    held_s  = 1'b0;
                    state_s = IDLE;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk190hz or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            cnt_r   <= 4'd0;
            cand_r  <= 4'd0;
            code_r  <= 4'd0;
            valid_r <= 1'b0;
            held_r  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rep_r   <= 8'd0;
`endif
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            cand_r  <= cand_s;
            code_r  <= code_s;
            valid_r <= valid_s;
            held_r  <= held_s;
`ifdef KEYPAD_REPEAT_EN
            rep_r   <= rep_s;
`endif
        end
    end

    assign key_code  = code_r;
    assign key_valid = valid_r;
    assign key_held  = held_r;

endmodule

// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 matrix keypad scanner with debounced key codes.
// Ports:
//   clk190hz  in   scan clock (rising edge)
//   rst_n     in   async active-low reset
//   col[3:0]  in   column sense, active high, already synchronised
//   row[3:0]  out  one-hot active-high row drive
//   key_code  out  code (4*row + col) of the last accepted key
//   key_valid out  one-cycle pulse on accept (or auto-repeat)
//   key_held  out  high from acceptance until debounced release
// Optional: define KEYPAD_REPEAT_EN to enable auto-repeat every REPEAT_SCANS scans.
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_SCANS = 2,
    parameter int REPEAT_SCANS   = 24
) (
    input  logic       clk190hz,
    input  logic       rst_n,
    input  logic [3:0] col,
    output logic [3:0] row,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    // Reject out-of-range configurations at elaboration.
    if ((DEBOUNCE_SCANS < 1) || (DEBOUNCE_SCANS > 15) ||
        (REPEAT_SCANS < 1) || (REPEAT_SCANS > 255)) begin : g_bad_params
        $error("keypad_scan: parameter out of range");
    end

    logic [3:0] row_r;
    logic [1:0] row_idx_r;
    logic [1:0] hits_r;
    logic [3:0] code_r;
    logic [1:0] samp_cnt_s;
    logic [2:0] sum_s;
    logic [1:0] tot_s;
    logic [3:0] code_nxt_s;
    logic       scan_done_s;
    scan_res_t  res_s;

    // Fold the current row's sample into the running scan totals.
    always_comb begin
        samp_cnt_s  = bit_count_sat(col);
        sum_s       = {1'b0, hits_r} + {1'b0, samp_cnt_s};
        tot_s       = (sum_s >= 3'd2) ? 2'd2 : sum_s[1:0];
        code_nxt_s  = (hits_r == 2'd0) ? {row_idx_r, col_index(col)} : code_r;
        scan_done_s = (row_idx_r == 2'd3);
        case (tot_s)
            2'd0:    res_s = NONE;
            2'd1:    res_s = SINGLE;
            default: res_s = MULTI;
        endcase
    end

    // Row drive rotation and scan accumulators; cleared as each scan completes.
    always_ff @(posedge clk190hz or negedge rst_n) begin
        if (!rst_n) begin
            row_r     <= 4'b0001;
            row_idx_r <= 2'd0;
            hits_r    <= 2'd0;
            code_r    <= 4'd0;
        end else begin
            row_r     <= {row_r[2:0], row_r[3]};
            row_idx_r <= row_idx_r + 2'd1;
            if (scan_done_s) begin
                hits_r <= 2'd0;
                code_r <= 4'd0;
            end else begin
                hits_r <= tot_s;
                code_r <= code_nxt_s;
            end
        end
    end

    assign row = row_r;

    keypad_debounce #(
        .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
`ifdef KEYPAD_REPEAT_EN
        ,
        .REPEAT_SCANS(REPEAT_SCANS)
`endif
    ) u_debounce (
        .clk190hz (clk190hz),
        .rst_n    (rst_n),
        .res_valid(scan_done_s),
        .res      (res_s),
        .res_code (code_nxt_s),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_held (key_held)
    );

endmodule
